dmem_req_adapter: RTL and testbench

- Request-side front end for the synchronous single-port data memory macro wrapper.
- Accepts byte/half/word load-store requests from the core over a valid/ready handshake, checks alignment, and drives the memory's word address, byte write enables and replicated write data.
- Aligns and extends the one-cycle-latency read data, then returns exactly one response per request through a 3-entry response queue with valid/ready backpressure.

---
 rtl/dmem_pkg.sv | 35 +++
 rtl/dmem_rsp_fifo.sv | 54 +++++
 rtl/dmem_req_adapter.sv | 124 ++++++++++++
 tb/tb_dmem_req_adapter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory request adapter: access sizes, response record, load alignment.
// Pure declarations; no state, no timing.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'd0,
        SZ_H   = 2'd1,
        SZ_W   = 2'd2,
        SZ_ILL = 2'd3
    } size_e;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    localparam int RSPQ_DEPTH = 3;

    // Shift the addressed lane down to bit 0, then extend from the access width.
    function automatic logic [31:0] load_align(
        input logic [31:0] rdata,
        input logic [1:0]  offset,
        input size_e       size,
        input logic        is_unsigned
    );
        logic [31:0] sh;
        sh = rdata >> {offset, 3'b000};
        case (size)
            SZ_B:    load_align = is_unsigned ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            SZ_H:    load_align = is_unsigned ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: load_align = sh;
        endcase
    endfunction

endpackage

// File: rtl/dmem_rsp_fifo.sv
// In-order response queue; head visible combinationally, push/pop take effect on the next edge.
// No internal backpressure: the producer guarantees it never pushes into a full queue.
module dmem_rsp_fifo
    import dmem_pkg::*;
#(
    parameter int DEPTH = RSPQ_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  rsp_t                         i_push_dat,
    input  logic                         i_pop,
    output rsp_t                         o_head_dat,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    rsp_t            r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_pop;

    // Pointers wrap explicitly because DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        ptr_next = (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign w_pop      = i_pop && (r_count != '0);
    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_count    = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= ptr_next(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_push_dat;
    end

endmodule

// File: rtl/dmem_req_adapter.sv
// Core-to-memory request front end: alignment check, byte enables, read-data alignment; 2-cycle response latency.
// Request ready drops when queued plus in-flight responses would reach the queue depth; no comb path from i_rsp_ready.
module dmem_req_adapter
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 2048,
    parameter int ADDR_WIDTH  = $clog2(DEPTH),
    parameter int DATA_WIDTH  = 32,
    parameter int DATA_BYTES  = DATA_WIDTH/8,
    parameter int BADDR_WIDTH = ADDR_WIDTH + $clog2(DATA_BYTES)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_we,
    input  logic [BADDR_WIDTH-1:0]  i_req_addr,
    input  logic [1:0]              i_req_size,
    input  logic                    i_req_unsigned,
    input  logic [DATA_WIDTH-1:0]   i_req_wdata,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
    output logic                    o_rsp_err,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic [DATA_WIDTH-1:0]   o_mem_wdata,
    output logic [DATA_BYTES-1:0]   o_mem_wen,
    input  logic [DATA_WIDTH-1:0]   i_mem_rdata
);
    localparam int QCW = $clog2(RSPQ_DEPTH+1);
    localparam int OCW = QCW + 1;

    size_e            w_size;
    logic [1:0]       w_off;
    logic             w_err;
    logic             w_accept;
    logic [3:0]       w_mask;
    logic [QCW-1:0]   w_q_count;
    logic             w_pop;
    rsp_t             w_push_dat;
    rsp_t             w_head_dat;

    logic             r_s1_vld;
    logic             r_s1_we;
    logic             r_s1_err;
    logic             r_s1_uns;
    size_e            r_s1_size;
    logic [1:0]       r_s1_off;

    assign w_size = size_e'(i_req_size);
    assign w_off  = i_req_addr[1:0];
    assign w_err  = (w_size == SZ_ILL)
                 || (w_size == SZ_H && w_off[0])
                 || (w_size == SZ_W && w_off != 2'b00);

    // Counting the stage-1 slot reserves queue space for the response already in flight.
    assign o_req_ready = rst_n && ((OCW'(w_q_count) + OCW'(r_s1_vld)) < OCW'(RSPQ_DEPTH));
    assign w_accept    = i_req_valid && o_req_ready;

    always_comb begin
        w_mask      = 4'b1111;
        o_mem_wdata = i_req_wdata;
        case (w_size)
            SZ_B: begin
                w_mask      = 4'b0001;
                o_mem_wdata = {4{i_req_wdata[7:0]}};
            end
            SZ_H: begin
                w_mask      = 4'b0011;
                o_mem_wdata = {2{i_req_wdata[15:0]}};
            end
            default: begin
                w_mask      = 4'b1111;
                o_mem_wdata = i_req_wdata;
            end
        endcase
    end

    assign o_mem_addr = i_req_addr[BADDR_WIDTH-1:2];
    assign o_mem_wen  = (w_accept && i_req_we && !w_err) ? DATA_BYTES'(w_mask << w_off) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_we   <= 1'b0;
            r_s1_err  <= 1'b0;
            r_s1_uns  <= 1'b0;
            r_s1_size <= SZ_B;
            r_s1_off  <= 2'b00;
        end else begin
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_s1_we   <= i_req_we;
                r_s1_err  <= w_err;
                r_s1_uns  <= i_req_unsigned;
                r_s1_size <= w_size;
                r_s1_off  <= w_off;
            end
        end
    end

    // Memory data arrives this cycle for the request accepted last cycle.
    assign w_push_dat.rdata = (!r_s1_we && !r_s1_err)
                            ? load_align(i_mem_rdata, r_s1_off, r_s1_size, r_s1_uns) : 32'd0;
    assign w_push_dat.err   = r_s1_err;

    assign o_rsp_valid = (w_q_count != '0);
    assign w_pop       = o_rsp_valid && i_rsp_ready;
    assign o_rsp_rdata = o_rsp_valid ? w_head_dat.rdata : '0;
    assign o_rsp_err   = o_rsp_valid ? w_head_dat.err : 1'b0;

    dmem_rsp_fifo #(
        .DEPTH (RSPQ_DEPTH)
    ) u_rspq (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (r_s1_vld),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .o_head_dat (w_head_dat),
        .o_count    (w_q_count)
    );

endmodule

// File: tb/tb_dmem_req_adapter.sv
// Bench for dmem_req_adapter: byte-array reference memory feeds a response scoreboard,
// plus directed checks of latency, backpressure and asynchronous reset.
module tb_dmem_req_adapter;

    logic        clk;
    logic        rst_n;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [12:0] i_req_addr;
    logic [1:0]  i_req_size;
    logic        i_req_unsigned;
    logic [31:0] i_req_wdata;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic [10:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_wen;
    logic [31:0] i_mem_rdata;

    dmem_req_adapter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_we       (i_req_we),
        .i_req_addr     (i_req_addr),
        .i_req_size     (i_req_size),
        .i_req_unsigned (i_req_unsigned),
        .i_req_wdata    (i_req_wdata),
        .o_rsp_valid    (o_rsp_valid),
        .i_rsp_ready    (i_rsp_ready),
        .o_rsp_rdata    (o_rsp_rdata),
        .o_rsp_err      (o_rsp_err),
        .o_mem_addr     (o_mem_addr),
        .o_mem_wdata    (o_mem_wdata),
        .o_mem_wen      (o_mem_wen),
        .i_mem_rdata    (i_mem_rdata)
    );

    typedef struct {
        logic [31:0] rd;
        logic        err;
        bit          has_lit;
        logic [31:0] lit;
    } sb_t;

    sb_t         exp_q [$];
    logic [31:0] mem [2048];
    logic [7:0]  ref_mem [8192];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    bit          cur_has_lit = 0;
    logic [31:0] cur_lit = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Synchronous single-port memory, one-cycle read latency.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (o_mem_wen[b]) mem[o_mem_addr][8*b +: 8] <= o_mem_wdata[8*b +: 8];
        i_mem_rdata <= mem[o_mem_addr];
    end

    // Monitor: accepts feed the reference model and scoreboard, responses are popped and compared.
    always @(negedge clk) begin
        int          nb;
        int          a;
        logic        e;
        logic [31:0] v;
        logic [31:0] ew;
        logic [31:0] ewd;
        sb_t         s;
        if (rst_n) begin
            if (i_req_valid && o_req_ready) begin
                nb = 1 << i_req_size;
                a  = int'(i_req_addr);
                e  = (i_req_size == 2'd3) || ((a % nb) != 0);
                chk("mem_addr", 32'(o_mem_addr), 32'(a / 4));
                ew = (i_req_we && !e) ? (((32'd1 << nb) - 32'd1) << (a % 4)) : 32'd0;
                chk("mem_wen", 32'(o_mem_wen), ew);
                if (i_req_we && i_req_size != 2'd3) begin
                    ewd = (nb == 1) ? {4{i_req_wdata[7:0]}} :
                          (nb == 2) ? {2{i_req_wdata[15:0]}} : i_req_wdata;
                    chk("mem_wdata", o_mem_wdata, ewd);
                end
                v = '0;
                if (!e) begin
                    if (i_req_we) begin
                        for (int i = 0; i < nb; i++) ref_mem[a+i] = 8'(i_req_wdata >> (8*i));
                    end else begin
                        for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[a+i]) << (8*i));
                        if (!i_req_unsigned && nb < 4 && v[8*nb-1])
                            v = v | ~((32'd1 << (8*nb)) - 32'd1);
                    end
                end
                s.rd = v; s.err = e; s.has_lit = cur_has_lit; s.lit = cur_lit;
                exp_q.push_back(s);
            end
            if (o_rsp_valid && i_rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'(o_rsp_valid), 32'd0);
                end else begin
                    s = exp_q.pop_front();
                    chk("rsp_rdata", o_rsp_rdata, s.rd);
                    chk("rsp_err", 32'(o_rsp_err), 32'(s.err));
                    if (s.has_lit) chk("rsp_lit", o_rsp_rdata, s.lit);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n)
            assert (int'(dut.w_q_count) + int'(dut.r_s1_vld) <= 3)
            else $error("response queue occupancy exceeded 3");
    end

    // Called at cycle start (#1 after posedge); returns at the start of the cycle after acceptance.
    task automatic send(input logic we, input logic [12:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata,
                        input bit has_lit, input logic [31:0] lit);
        bit ok;
        ok = 0;
        cur_has_lit    = has_lit;
        cur_lit        = lit;
        i_req_we       = we;
        i_req_addr     = addr;
        i_req_size     = size;
        i_req_unsigned = uns;
        i_req_wdata    = wdata;
        i_req_valid    = 1'b1;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            if (o_req_ready) ok = 1;
            @(posedge clk); #1;
        end
        i_req_valid = 1'b0;
        chk("req_accept", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        for (int t = 0; t < 40 && exp_q.size() != 0; t++) @(posedge clk);
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [12:0] bp_addr [4];
        logic [1:0]  bp_size [4];
        int          c0;
        bp_addr = '{13'h010, 13'h013, 13'h012, 13'h020};
        bp_size = '{2'd2, 2'd0, 2'd1, 2'd2};

        for (int i = 0; i < 2048; i++) mem[i] = '0;
        for (int i = 0; i < 8192; i++) ref_mem[i] = '0;
        rst_n = 1'b0; i_req_valid = 1'b0; i_req_we = 1'b0; i_req_addr = '0;
        i_req_size = '0; i_req_unsigned = 1'b0; i_req_wdata = '0; i_rsp_ready = 1'b1;

        #12;
        chk("rst_req_ready", 32'(o_req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        chk("rst_rsp_rdata", o_rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(o_rsp_err), 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(o_req_ready), 32'd1);
        @(posedge clk); #1;

        // Word store, then response latency: not visible at N+1, visible at N+2.
        send(1'b1, 13'h010, 2'd2, 1'b0, 32'hDEADBEEF, 1, 32'h0);
        @(negedge clk); chk("lat_n1_valid", 32'(o_rsp_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk); chk("lat_n2_valid", 32'(o_rsp_valid), 32'd1);
        @(posedge clk); #1;

        send(1'b0, 13'h010, 2'd2, 1'b0, 32'h0, 1, 32'hDEADBEEF);
        c0 = cyc;
        send(1'b0, 13'h013, 2'd0, 1'b0, 32'h0, 1, 32'hFFFFFFDE);
        send(1'b0, 13'h013, 2'd0, 1'b1, 32'h0, 1, 32'h000000DE);
        send(1'b0, 13'h012, 2'd1, 1'b0, 32'h0, 1, 32'hFFFFDEAD);
        chk("throughput_cycles", 32'(cyc - c0), 32'd3);
        send(1'b0, 13'h010, 2'd1, 1'b1, 32'h0, 1, 32'h0000BEEF);

        send(1'b1, 13'h011, 2'd0, 1'b0, 32'h000000A5, 1, 32'h0);
        send(1'b0, 13'h010, 2'd2, 1'b0, 32'h0, 1, 32'hDEADA5EF);
        send(1'b1, 13'h022, 2'd1, 1'b0, 32'h00001234, 1, 32'h0);
        send(1'b0, 13'h020, 2'd2, 1'b0, 32'h0, 1, 32'h12340000);
        send(1'b0, 13'h021, 2'd0, 1'b1, 32'h0, 0, 32'h0);

        // Misaligned / illegal requests: no write, err response with zero data.
        send(1'b1, 13'h012, 2'd2, 1'b0, 32'h55555555, 1, 32'h0);
        send(1'b0, 13'h011, 2'd1, 1'b0, 32'h0, 1, 32'h0);
        send(1'b0, 13'h010, 2'd3, 1'b0, 32'h0, 1, 32'h0);
        send(1'b1, 13'h016, 2'd3, 1'b0, 32'h77777777, 1, 32'h0);
        send(1'b0, 13'h010, 2'd2, 1'b0, 32'h0, 1, 32'hDEADA5EF);
        send(1'b0, 13'h014, 2'd2, 1'b0, 32'h0, 1, 32'h0);
        drain();

        // Backpressure: four back-to-back loads with the consumer stalled.
        i_rsp_ready = 1'b0; cur_has_lit = 0;
        i_req_we = 1'b0; i_req_unsigned = 1'b0; i_req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_req_addr = bp_addr[k]; i_req_size = bp_size[k];
            @(negedge clk); chk("bp_ready_accept", 32'(o_req_ready), 32'd1);
            @(posedge clk); #1;
        end
        i_req_addr = bp_addr[3]; i_req_size = bp_size[3];
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); chk("bp_ready_full", 32'(o_req_ready), 32'd0);
            @(posedge clk); #1;
        end
        i_rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_r0", 32'(o_req_ready), 32'd0);
        chk("bp_valid_r0", 32'(o_rsp_valid), 32'd1);
        @(posedge clk); #1;
        @(negedge clk); chk("bp_ready_r1", 32'(o_req_ready), 32'd1);
        @(posedge clk); #1; i_req_valid = 1'b0;
        @(negedge clk); @(posedge clk); #1;
        @(negedge clk); chk("bp_tail_valid_r3", 32'(o_rsp_valid), 32'd1);
        @(posedge clk); #1;
        @(negedge clk); chk("bp_empty_r4", 32'(o_rsp_valid), 32'd0);
        @(posedge clk); #1;
        drain();

        // Asynchronous reset with one response queued and one in flight.
        i_rsp_ready = 1'b0;
        send(1'b0, 13'h010, 2'd2, 1'b0, 32'h0, 1, 32'hDEADA5EF);
        send(1'b0, 13'h020, 2'd2, 1'b0, 32'h0, 1, 32'h12340000);
        @(negedge clk); chk("rst_pre_valid", 32'(o_rsp_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        chk("arst_req_ready", 32'(o_req_ready), 32'd0);
        chk("arst_rsp_rdata", o_rsp_rdata, 32'd0);
        chk("arst_rsp_err", 32'(o_rsp_err), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1; i_rsp_ready = 1'b1;
        @(negedge clk); chk("rel_req_ready", 32'(o_req_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk("rel_no_stale", 32'(o_rsp_valid), 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        send(1'b0, 13'h010, 2'd2, 1'b0, 32'h0, 1, 32'hDEADA5EF);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
